// File: rtl/prior_pkg.sv
// Shared types and mode constants for the priority arbiter.
package prior_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

endpackage

// File: rtl/prior_enc_n.sv
// Combinational winner search: index ptr has top priority, then descending with wrap.
// With ptr = N-1 this degenerates to plain highest-index-wins.
module prior_enc_n #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    int         c;
    logic [W-1:0] ci;

    always_comb begin
        idx = '0;
        any = 1'b0;
        c   = 0;
        ci  = '0;
        for (int j = 0; j < N; j++) begin
            c = int'(ptr) - j;
            if (c < 0) begin
                c = c + N;
            end
            ci = W'(c);
            if (!any && req[ci]) begin
                any = 1'b1;
                idx = ci;
            end
        end
    end

endmodule

// File: rtl/prior_arb.sv
// Registered N-way arbiter with valid/ready grant handshake.
// Fixed priority (highest index wins) or round-robin via a rotating priority pointer.
module prior_arb
    import prior_pkg::*;
#(
    parameter int N       = 8,
    parameter int RR_MODE = PRIO_FIXED,
    localparam int W      = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic         gnt_vld,
    input  logic         gnt_rdy,
    output logic [W-1:0] gnt_idx,
    output logic [N-1:0] gnt_oh
);

    localparam logic [W-1:0] PTR_TOP = W'(N - 1);

    state_t       state_q, state_d;
    logic [W-1:0] idx_q, idx_d;
    logic [N-1:0] oh_q, oh_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         accept;
    logic [W-1:0] enc_idx;
    logic         enc_any;

    // Re-arbitration on accept already sees the advanced pointer, so the
    // requester just served drops to lowest priority in the same cycle.
    prior_enc_n #(.N(N)) u_enc (
        .req (req),
        .ptr (ptr_d),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        accept  = (state_q == GRANT) && gnt_rdy;
        state_d = state_q;
        idx_d   = idx_q;
        oh_d    = oh_q;
        ptr_d   = ptr_q;

        if (RR_MODE == PRIO_RR && accept) begin
            ptr_d = (idx_q == '0) ? PTR_TOP : idx_q - W'(1);
        end

        case (state_q)
            IDLE: begin
                if (enc_any) begin
                    state_d = GRANT;
                    idx_d   = enc_idx;
                    oh_d    = N'(1) << enc_idx;
                end
            end
            GRANT: begin
                if (accept) begin
                    if (enc_any) begin
                        idx_d = enc_idx;
                        oh_d  = N'(1) << enc_idx;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        oh_d    = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                oh_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            oh_q    <= '0;
            ptr_q   <= PTR_TOP;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt_vld = (state_q == GRANT);
    assign gnt_idx = idx_q;
    assign gnt_oh  = oh_q;

endmodule

// File: tb/tb_prior_arb.sv
// Three arbiter instances (N=4 fixed, N=8 RR, N=5 RR) checked against a
// behavioural grant/pointer model, with directed scenarios then random traffic.
module tb_prior_arb;

    logic clk;
    logic rst_n;
    logic [7:0] rq [3];
    logic       rdy [3];

    logic       ovld [3];
    logic [2:0] oidx [3];
    logic [7:0] ooh  [3];

    logic [3:0] req4, oh4;
    logic [1:0] idx4;
    logic [7:0] req8, oh8;
    logic [2:0] idx8;
    logic [4:0] req5, oh5;
    logic [2:0] idx5;
    logic       vld4, vld8, vld5;

    int nn [3] = '{4, 8, 5};
    int rr [3] = '{0, 1, 1};
    int m_vld [3];
    int m_idx [3];
    int m_ptr [3];

    int tests = 0;
    int fails = 0;

    assign req4 = rq[0][3:0];
    assign req8 = rq[1];
    assign req5 = rq[2][4:0];

    assign ovld[0] = vld4;
    assign ovld[1] = vld8;
    assign ovld[2] = vld5;
    assign oidx[0] = {1'b0, idx4};
    assign oidx[1] = idx8;
    assign oidx[2] = idx5;
    assign ooh[0]  = {4'b0, oh4};
    assign ooh[1]  = oh8;
    assign ooh[2]  = {3'b0, oh5};

    prior_arb #(.N(4), .RR_MODE(0)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .gnt_vld(vld4),
        .gnt_rdy(rdy[0]), .gnt_idx(idx4), .gnt_oh(oh4));
    prior_arb #(.N(8), .RR_MODE(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .gnt_vld(vld8),
        .gnt_rdy(rdy[1]), .gnt_idx(idx8), .gnt_oh(oh8));
    prior_arb #(.N(5), .RR_MODE(1)) dut5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .gnt_vld(vld5),
        .gnt_rdy(rdy[2]), .gnt_idx(idx5), .gnt_oh(oh5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(int d, int r);
        int w;
        w = -1;
        if (rr[d] == 0) begin
            for (int i = 0; i < nn[d]; i++)
                if (((r >> i) & 1) == 1) w = i;
        end else begin
            for (int j = nn[d] - 1; j >= 0; j--)
                if (((r >> ((m_ptr[d] - j + nn[d]) % nn[d])) & 1) == 1)
                    w = (m_ptr[d] - j + nn[d]) % nn[d];
        end
        return w;
    endfunction

    task automatic model_edge();
        int r;
        for (int d = 0; d < 3; d++) begin
            r = int'(rq[d]) & ((1 << nn[d]) - 1);
            if (!rst_n) begin
                m_vld[d] = 0;
                m_idx[d] = 0;
                m_ptr[d] = nn[d] - 1;
            end else if (m_vld[d] == 0) begin
                if (r != 0) begin
                    m_vld[d] = 1;
                    m_idx[d] = pick(d, r);
                end
            end else if (rdy[d]) begin
                if (rr[d] == 1)
                    m_ptr[d] = (m_idx[d] == 0) ? nn[d] - 1 : m_idx[d] - 1;
                if (r != 0) begin
                    m_idx[d] = pick(d, r);
                end else begin
                    m_vld[d] = 0;
                    m_idx[d] = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        int exp_oh;
        for (int d = 0; d < 3; d++) begin
            exp_oh = (m_vld[d] != 0) ? (1 << m_idx[d]) : 0;
            tests++;
            assert (ovld[d] === (m_vld[d] != 0)) else begin
                fails++;
                $error("FAIL vld dut%0d t=%0t got %0b exp %0d", d, $time, ovld[d], m_vld[d]);
            end
            tests++;
            assert (oidx[d] === 3'(m_idx[d])) else begin
                fails++;
                $error("FAIL idx dut%0d t=%0t got %0d exp %0d", d, $time, oidx[d], m_idx[d]);
            end
            tests++;
            assert (ooh[d] === 8'(exp_oh)) else begin
                fails++;
                $error("FAIL oh dut%0d t=%0t got %b exp %b", d, $time, ooh[d], 8'(exp_oh));
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic chk_val(string tag, int got, int exp);
        tests++;
        assert (got == exp) else begin
            fails++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            rq[d] = 8'h00;
            rdy[d] = 1'b0;
            m_vld[d] = 0;
            m_idx[d] = 0;
            m_ptr[d] = nn[d] - 1;
        end
        step();
        step();
        chk_val("reset_vld8", int'(ovld[1]), 0);
        rst_n = 1'b1;
        step();

        // fixed N=4: 0110 -> winner 2
        rq[0] = 8'h06; rdy[0] = 1'b1;
        step();
        chk_val("fix_idx2", int'(oidx[0]), 2);
        chk_val("fix_oh4", int'(ooh[0]), 4);
        rq[0] = 8'h00;
        step();
        chk_val("fix_idle", int'(ovld[0]), 0);

        // fixed N=4: grant held through req change until accept
        rq[0] = 8'h08; rdy[0] = 1'b0;
        step();
        rq[0] = 8'h01;
        step();
        step();
        chk_val("hold_idx3", int'(oidx[0]), 3);
        rdy[0] = 1'b1;
        step();
        chk_val("after_acc_idx0", int'(oidx[0]), 0);
        chk_val("after_acc_vld", int'(ovld[0]), 1);
        rq[0] = 8'h00;
        step();

        // RR N=8 all requesting: descending sequence with wrap, no bubble
        rq[1] = 8'hFF; rdy[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_val("rr_ff_seq", int'(oidx[1]), (7 - i + 16) % 8);
            chk_val("rr_ff_vld", int'(ovld[1]), 1);
        end

        // RR alternation, N=8 on 0x81 and N=5 on 10001
        rst_n = 1'b0; rq[1] = 8'h00;
        step();
        rst_n = 1'b1;
        rq[1] = 8'h81; rq[2] = 8'h11; rdy[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_val("rr_81", int'(oidx[1]), (i % 2 == 0) ? 7 : 0);
            chk_val("rr_n5", int'(oidx[2]), (i % 2 == 0) ? 4 : 0);
        end
        rq[1] = 8'h00; rq[2] = 8'h00;
        step();

        // reset mid-grant drops it, first grant after release picks highest
        rq[1] = 8'h20; rdy[1] = 1'b0;
        step();
        chk_val("pre_rst_idx5", int'(oidx[1]), 5);
        rst_n = 1'b0;
        step();
        chk_val("rst_vld", int'(ovld[1]), 0);
        chk_val("rst_oh", int'(ooh[1]), 0);
        rst_n = 1'b1; rq[1] = 8'h24;
        step();
        chk_val("post_rst_idx5", int'(oidx[1]), 5);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 3; d++) begin
                rq[d]  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                rdy[d] = ($urandom_range(0, 2) != 0);
            end
            rst_n = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
